clock_set_controller: RTL and testbench
=======================================

CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100_000_000, giving CLK100MHZ cycles per 1 s tick.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, giving the stable cycles required to accept a button level (10 ms).
REQ-003 The block SHALL have parameter BLINK_DIV, default 25_000_000, giving cycles per blink-phase toggle (2 Hz blink).
REQ-004 Port CLK100MHZ, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-005 Port R, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port BTN_MODE, input, 1 bit: raw, asynchronous, active-high mode button.
REQ-007 Port BTN_INC, input, 1 bit: raw, asynchronous, active-high increment button.
REQ-008 Port seconds, output, 6 bits: current seconds, 0-59, binary.
REQ-009 Port minutes, output, 6 bits: current minutes, 0-59, binary.
REQ-010 Port mode, output, 2 bits: FSM state; 0 RUN, 1 SET_MIN, 2 SET_SEC.
REQ-011 Port blank, output, 2 bits: bit1 blanks the minute digits and bit0 blanks the second digits; this port drives the downstream split/decode/scan display path.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer and then a debouncer that updates its accepted level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-013 Each accepted-level 0->1 transition SHALL produce a registered one-cycle press pulse; 1->0 transitions produce nothing; holding a button produces exactly one pulse.
REQ-014 A clean raw rising edge held stable SHALL change the affected register exactly DEBOUNCE_CYCLES+4 cycles later.
REQ-015 FSM transitions on a MODE pulse SHALL be RUN->SET_MIN->SET_SEC->RUN; with no MODE pulse the state holds.
REQ-016 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and wrap; seconds SHALL increment on the wrap cycle, visible on the next edge.
REQ-017 seconds 59 SHALL wrap to 0 with minutes+1 on the same edge, and minutes 59 SHALL wrap to 0 (59:59 -> 00:00).
REQ-018 In SET_MIN and SET_SEC, the prescaler SHALL be held at 0 and no tick occurs.
REQ-019 On RUN re-entry, the first tick SHALL occur exactly TICK_DIV cycles later.
REQ-020 An INC pulse in SET_MIN SHALL set minutes to (minutes+1) mod 60 on the next edge, with seconds unchanged.
REQ-021 An INC pulse in SET_SEC SHALL set seconds to (seconds+1) mod 60 on the next edge, with no carry into minutes.
REQ-022 An INC pulse in RUN SHALL be ignored.
REQ-023 When MODE and INC pulse in the same cycle, MODE SHALL win: the state advances and INC is dropped.
REQ-024 A blink counter SHALL count 0..BLINK_DIV-1 free-running and toggle a phase bit on wrap.
REQ-025 blank SHALL equal {phase & SET_MIN, phase & SET_SEC}, registered, and SHALL be 00 in RUN.
REQ-026 All outputs SHALL be registered, with no combinational path from button inputs.
REQ-027 The state encoding value 3 SHALL be unreachable; if ever entered, the FSM returns to RUN on the next edge.

Reset
REQ-028 R low SHALL immediately force seconds=0, minutes=0, mode=RUN, blank=00, and clear the prescaler, blink counter, phase, debouncer counters and accepted levels, synchronizers and press pulses.
REQ-029 A press in progress at reset assertion SHALL be discarded.
REQ-030 A button already held at reset release SHALL generate one press after DEBOUNCE_CYCLES+4 cycles.
REQ-031 Reset deassertion SHALL be applied synchronously to CLK100MHZ, through a 2-flop release synchronizer, before it reaches internal logic.

Structure
REQ-032 A shared package clock_pkg SHALL hold the state enum (RUN, SET_MIN, SET_SEC), the constant MAX_SEC_MIN = 59, and the 6-bit time field width.
REQ-033 One sub-module, button_debounce (synchronizer + debouncer + edge pulse), SHALL be instantiated twice.
REQ-034 The target size SHALL be 150-300 RTL lines total.

Verification (TICK_DIV=10, DEBOUNCE_CYCLES=4, BLINK_DIV=3)
REQ-035 Reset, then 600 ticks -> time 10:00 with blank=00 throughout; preload 59:59 and apply 1 tick -> 00:00.
REQ-036 BTN_MODE held 20 cycles -> exactly one pulse, mode=1 at cycle 8 after the rising edge; a 3-cycle glitch -> no change.
REQ-037 In SET_MIN from 58:30, 3 INC presses -> 01:30; then MODE, then 31 INC presses -> 01:01, with minutes unchanged.
REQ-038 MODE and INC rising in the same cycle in SET_MIN -> mode=2, minutes unchanged; after MODE to RUN -> seconds advances exactly 10 cycles later.
REQ-039 In SET_SEC, blank toggles 00/01 every 3 cycles; in SET_MIN, blank toggles 00/10; in RUN, blank stays 00.
REQ-040 Assert R mid-debounce while in SET_SEC at 12:34 -> all outputs zero/RUN immediately; release with BTN_INC held -> no increment and the clock runs from 00:00.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the settable MM:SS clock controller.
package clock_pkg;

  localparam int unsigned TIME_W = 6;
  localparam logic [TIME_W-1:0] MAX_SEC_MIN = 6'd59;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MIN = 2'd1,
    SET_SEC = 2'd2
  } state_e;

  // Modulo-60 increment shared by ticking and manual setting.
  function automatic logic [TIME_W-1:0] inc_wrap(input logic [TIME_W-1:0] v);
    return (v == MAX_SEC_MIN) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw button -> 2-flop synchronizer -> level debouncer -> one-cycle press pulse.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;
  logic             press_q, press_d;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    cnt_d        = '0;
    level_d      = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    level_prev_d = level_q;
    press_d      = level_q & ~level_prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_set_controller.sv
// MM:SS clock with MODE/INC button setting and a blink mask for the field being edited.
//   state   | meaning
//   RUN     | prescaler runs, seconds tick, INC ignored, no blanking
//   SET_MIN | time frozen, INC bumps minutes, minute digits blink
//   SET_SEC | time frozen, INC bumps seconds (no carry), second digits blink
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_DIV       = 25_000_000
) (
  input  logic              CLK100MHZ,
  input  logic              R,
  input  logic              BTN_MODE,
  input  logic              BTN_INC,
  output logic [TIME_W-1:0] seconds,
  output logic [TIME_W-1:0] minutes,
  output logic [1:0]        mode,
  output logic [1:0]        blank
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Assert asynchronously, release only after two clean clock edges.
  logic rst_meta_q, rst_sync_q;
  always_ff @(posedge CLK100MHZ or negedge R) begin
    if (!R) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic mode_p, inc_p;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
    .clk(CLK100MHZ), .rst_n(rst_sync_q), .btn_raw(BTN_MODE), .press(mode_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
    .clk(CLK100MHZ), .rst_n(rst_sync_q), .btn_raw(BTN_INC), .press(inc_p)
  );

  state_e             mode_q, mode_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               phase_q, phase_d;
  logic [TIME_W-1:0]  sec_q, sec_d;
  logic [TIME_W-1:0]  min_q, min_d;
  logic [1:0]         blank_q, blank_d;
  logic               tick, blink_wrap;

  always_comb begin
    tick       = (mode_q == RUN) && (presc_q == PRESC_LAST);
    presc_d    = ((mode_q == RUN) && !tick) ? presc_q + 1'b1 : '0;
    blink_wrap = (blink_q == BLINK_LAST);
    blink_d    = blink_wrap ? '0 : blink_q + 1'b1;
    phase_d    = phase_q ^ blink_wrap;

    sec_d  = sec_q;
    min_d  = min_q;
    mode_d = mode_q;

    if (tick) begin
      sec_d = inc_wrap(sec_q);
      if (sec_q == MAX_SEC_MIN) min_d = inc_wrap(min_q);
    end

    // MODE takes priority; a coincident INC is dropped.
    case (mode_q)
      RUN:     if (mode_p) mode_d = SET_MIN;
      SET_MIN: if (mode_p) mode_d = SET_SEC;
               else if (inc_p) min_d = inc_wrap(min_q);
      SET_SEC: if (mode_p) mode_d = RUN;
               else if (inc_p) sec_d = inc_wrap(sec_q);
      default: mode_d = RUN;
    endcase

    blank_d = {phase_d & (mode_d == SET_MIN), phase_d & (mode_d == SET_SEC)};
  end

  always_ff @(posedge CLK100MHZ or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      mode_q  <= RUN;
      presc_q <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      sec_q   <= '0;
      min_q   <= '0;
      blank_q <= 2'b00;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      blank_q <= blank_d;
    end
  end

  assign seconds = sec_q;
  assign minutes = min_q;
  assign mode    = mode_q;
  assign blank   = blank_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with a cycle-level behavioural model.
module tb_clock_set_controller;

  localparam int TICK  = 10;
  localparam int DEB   = 4;
  localparam int BLINK = 3;
  localparam int LAT   = DEB + 4;

  logic       CLK100MHZ = 1'b0;
  logic       R         = 1'b0;
  logic       BTN_MODE  = 1'b0;
  logic       BTN_INC   = 1'b0;
  logic [5:0] seconds, minutes;
  logic [1:0] mode, blank;

  clock_set_controller #(
    .TICK_DIV(TICK), .DEBOUNCE_CYCLES(DEB), .BLINK_DIV(BLINK)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .R(R), .BTN_MODE(BTN_MODE), .BTN_INC(BTN_INC),
    .seconds(seconds), .minutes(minutes), .mode(mode), .blank(blank)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    int edge_n;
    bit is_mode;
  } ev_t;

  ev_t ev_q[$];
  int  cyc = 0;
  int  rel = 0;
  int  act = 0;
  int  run_cnt = 0;
  int  m_sec = 0, m_min = 0, m_mode = 0;
  int  n_pass = 0, n_total = 0;

  task automatic check(input string name, input int act_v, input int exp_v);
    n_total++;
    if (act_v == exp_v) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act_v, exp_v);
  endtask

  // Model: a press takes effect LAT edges after its raw rising edge; the
  // first functional edge is the third after R rises; time counts in
  // seconds mod 3600 while in RUN.
  always @(posedge CLK100MHZ) begin
    bit mode_ev, inc_ev;
    cyc = cyc + 1;
    if (!R) begin
      rel = 0; act = 0; run_cnt = 0;
      m_sec = 0; m_min = 0; m_mode = 0;
      ev_q.delete();
    end else begin
      rel = rel + 1;
      if (rel >= 3) begin
        mode_ev = 1'b0;
        inc_ev  = 1'b0;
        foreach (ev_q[i]) begin
          if (ev_q[i].edge_n == cyc) begin
            if (ev_q[i].is_mode) mode_ev = 1'b1;
            else                 inc_ev  = 1'b1;
          end
        end
        act = act + 1;
        if (m_mode == 0) begin
          run_cnt = run_cnt + 1;
          if (run_cnt == TICK) begin
            int total;
            run_cnt = 0;
            total = (m_min * 60 + m_sec + 1) % 3600;
            m_min = total / 60;
            m_sec = total % 60;
          end
        end else begin
          run_cnt = 0;
        end
        if (mode_ev) m_mode = (m_mode + 1) % 3;
        else if (inc_ev && m_mode == 1) m_min = (m_min + 1) % 60;
        else if (inc_ev && m_mode == 2) m_sec = (m_sec + 1) % 60;
      end
    end
  end

  always @(negedge CLK100MHZ) begin
    int ph, eb, exp_v;
    ph = (act / BLINK) % 2;
    eb = ((ph == 1 && m_mode == 1) ? 2 : 0) + ((ph == 1 && m_mode == 2) ? 1 : 0);
    if (!R) exp_v = 0;
    else    exp_v = (m_sec << 10) | (m_min << 4) | (m_mode << 2) | eb;
    check("cycle_outputs", int'({seconds, minutes, mode, blank}), exp_v);
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge CLK100MHZ);
      #1;
    end
  endtask

  task automatic sched(input bit is_mode);
    ev_t ev;
    ev.edge_n  = cyc + LAT;
    ev.is_mode = is_mode;
    ev_q.push_back(ev);
  endtask

  task automatic press_mode();
    BTN_MODE = 1'b1;
    sched(1'b1);
    step(12);
    BTN_MODE = 1'b0;
    step(12);
  endtask

  task automatic press_inc();
    BTN_INC = 1'b1;
    sched(1'b0);
    step(12);
    BTN_INC = 1'b0;
    step(12);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r1, s, e, cnt_a, cnt_b;

    step(3);
    check("reset_seconds", int'(seconds), 0);
    check("reset_minutes", int'(minutes), 0);
    check("reset_mode", int'(mode), 0);
    check("reset_blank", int'(blank), 0);
    R  = 1'b1;
    r0 = cyc;

    // 600 ticks -> 10:00, then run on to 59:59 and the full wrap
    wait_edge(r0 + 2 + 5999);
    check("run_0959_min", int'(minutes), 9);
    check("run_0959_sec", int'(seconds), 59);
    wait_edge(r0 + 2 + 6000);
    check("run_1000_min", int'(minutes), 10);
    check("run_1000_sec", int'(seconds), 0);
    check("run_1000_blank", int'(blank), 0);
    wait_edge(r0 + 2 + 35990);
    check("run_5959_min", int'(minutes), 59);
    check("run_5959_sec", int'(seconds), 59);
    wait_edge(r0 + 2 + 36000);
    check("wrap_0000_min", int'(minutes), 0);
    check("wrap_0000_sec", int'(seconds), 0);

    // 3-cycle glitch is rejected; a long hold gives exactly one MODE press
    BTN_MODE = 1'b1;
    step(3);
    BTN_MODE = 1'b0;
    step(20);
    check("glitch_mode", int'(mode), 0);
    s = cyc;
    BTN_MODE = 1'b1;
    sched(1'b1);
    wait_edge(s + LAT - 1);
    check("mode_before_latency", int'(mode), 0);
    wait_edge(s + LAT);
    check("mode_at_latency", int'(mode), 1);
    wait_edge(s + 20);
    BTN_MODE = 1'b0;
    step(12);
    check("mode_single_pulse", int'(mode), 1);

    // reach SET_MIN at 58:30 (two ticks elapse during the RUN pass-through)
    repeat ((58 - m_min + 60) % 60) press_inc();
    press_mode();
    repeat ((28 - m_sec + 60) % 60) press_inc();
    press_mode();
    press_mode();
    check("setup_mode", int'(mode), 1);
    check("setup_min", int'(minutes), 58);
    check("setup_sec", int'(seconds), 30);
    repeat (3) press_inc();
    check("inc_min_wrap_min", int'(minutes), 1);
    check("inc_min_wrap_sec", int'(seconds), 30);
    press_mode();
    check("to_set_sec", int'(mode), 2);
    repeat (31) press_inc();
    check("inc_sec_wrap_sec", int'(seconds), 1);
    check("inc_sec_wrap_min", int'(minutes), 1);

    // MODE and INC together: MODE wins
    press_mode();
    press_mode();
    check("back_set_min_mode", int'(mode), 1);
    check("back_set_min_sec", int'(seconds), 3);
    s = cyc;
    BTN_MODE = 1'b1;
    BTN_INC  = 1'b1;
    sched(1'b1);
    sched(1'b0);
    wait_edge(s + LAT - 1);
    check("both_before_mode", int'(mode), 1);
    wait_edge(s + LAT);
    check("both_mode", int'(mode), 2);
    check("both_min", int'(minutes), 1);
    check("both_sec", int'(seconds), 3);
    wait_edge(s + 12);
    BTN_MODE = 1'b0;
    BTN_INC  = 1'b0;
    step(12);

    // RUN re-entry: first tick exactly TICK cycles later
    s = cyc;
    BTN_MODE = 1'b1;
    sched(1'b1);
    e = s + LAT;
    wait_edge(e);
    check("reentry_mode", int'(mode), 0);
    wait_edge(e + TICK - 1);
    check("reentry_sec_before", int'(seconds), 3);
    wait_edge(e + TICK);
    check("reentry_sec_tick", int'(seconds), 4);
    BTN_MODE = 1'b0;
    step(12);

    // blink mask per mode
    cnt_a = 0;
    for (int i = 0; i < 12; i++) begin step(1); if (blank != 2'b00) cnt_a++; end
    check("blank_run_nonzero", cnt_a, 0);
    press_mode();
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (blank == 2'b10) cnt_a++;
      if (blank[0]) cnt_b++;
    end
    check("blank_setmin_on", cnt_a, 6);
    check("blank_setmin_bit0", cnt_b, 0);
    press_mode();
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (blank == 2'b01) cnt_a++;
      if (blank[1]) cnt_b++;
    end
    check("blank_setsec_on", cnt_a, 6);
    check("blank_setsec_bit1", cnt_b, 0);
    press_mode();
    cnt_a = 0;
    for (int i = 0; i < 12; i++) begin step(1); if (blank != 2'b00) cnt_a++; end
    check("blank_run_again", cnt_a, 0);

    // reset mid-debounce in SET_SEC at 12:34, release with INC held
    press_mode();
    repeat ((12 - m_min + 60) % 60) press_inc();
    press_mode();
    repeat ((34 - m_sec + 60) % 60) press_inc();
    check("pre_reset_mode", int'(mode), 2);
    check("pre_reset_min", int'(minutes), 12);
    check("pre_reset_sec", int'(seconds), 34);
    BTN_INC = 1'b1;
    step(5);
    R = 1'b0;
    #1;
    check("async_reset_sec", int'(seconds), 0);
    check("async_reset_min", int'(minutes), 0);
    check("async_reset_mode", int'(mode), 0);
    check("async_reset_blank", int'(blank), 0);
    step(3);
    R  = 1'b1;
    r1 = cyc;
    wait_edge(r1 + 2 + 2 * TICK - 1);
    check("post_reset_sec_1", int'(seconds), 1);
    wait_edge(r1 + 2 + 3 * TICK - 1);
    check("post_reset_sec_2", int'(seconds), 2);
    wait_edge(r1 + 2 + 3 * TICK);
    check("post_reset_sec_3", int'(seconds), 3);
    check("post_reset_min", int'(minutes), 0);
    check("post_reset_mode", int'(mode), 0);
    BTN_INC = 1'b0;
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
